// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU, debug and memory-side signals of the arbiter.
// slave = arbiter view, master = requester/memory side view.
interface mem_arbiter_if #(
   parameter int AW = 19,
   parameter int DW = 8
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_ad;
   logic [DW-1:0] cpu_wd;
   logic          cpu_ack;
   logic [DW-1:0] cpu_rd;
   logic          cpu_halt;
   logic          dbg_req;
   logic          dbg_gnt;
   logic          dbg_we;
   logic [AW-1:0] dbg_ad;
   logic [DW-1:0] dbg_wd;
   logic [DW-1:0] dbg_rd;
   logic          mem_we;
   logic [AW-1:0] mem_ad;
   logic [DW-1:0] mem_wd;
   logic [DW-1:0] mem_rd;

   modport slave (
      input  cpu_req, cpu_we, cpu_ad, cpu_wd,
      input  dbg_req, dbg_we, dbg_ad, dbg_wd,
      input  mem_rd,
      output cpu_ack, cpu_rd, cpu_halt,
      output dbg_gnt, dbg_rd,
      output mem_we, mem_ad, mem_wd
   );

   modport master (
      output cpu_req, cpu_we, cpu_ad, cpu_wd,
      output dbg_req, dbg_we, dbg_ad, dbg_wd,
      output mem_rd,
      input  cpu_ack, cpu_rd, cpu_halt,
      input  dbg_gnt, dbg_rd,
      input  mem_we, mem_ad, mem_wd
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous byte memory between CPU and debug.
// Debug owns the port per burst; a hold-off window protects pending CPU work.
module mem_arbiter #(
   parameter int AW      = 19,
   parameter int DW      = 8,
   parameter int CPU_MIN = 4
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);
   localparam int HW = (CPU_MIN > 0) ? $clog2(CPU_MIN + 1) : 1;

   typedef enum logic [2:0] {
      IDLE,
      C_ADDR,
      C_DATA,
      C_ACK,
      D_OWN,
      D_REL
   } state_t;

   state_t        state, state_n;
   logic [HW-1:0] holdoff, holdoff_n;
   logic          ack, ack_n;
   logic          halt, halt_n;
   logic          gnt, gnt_n;
   logic [DW-1:0] rd, rd_n;

   // state, hold-off counter and registered handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         holdoff <= '0;
         ack     <= 1'b0;
         halt    <= 1'b0;
         gnt     <= 1'b0;
         rd      <= '0;
      end else begin
         state   <= state_n;
         holdoff <= holdoff_n;
         ack     <= ack_n;
         halt    <= halt_n;
         gnt     <= gnt_n;
         rd      <= rd_n;
      end
   end

   // next-state decisions and memory port mux decoded from state
   always_comb begin
      state_n    = state;
      holdoff_n  = (holdoff != '0) ? holdoff - 1'b1 : holdoff;
      ack_n      = 1'b0;
      halt_n     = halt;
      gnt_n      = gnt;
      rd_n       = rd;
      bus.mem_we = 1'b0;
      bus.mem_ad = {AW{1'b0}};
      bus.mem_wd = {DW{1'b0}};
      unique case (state)
         IDLE: begin
            if (bus.dbg_req && (holdoff == '0 || !bus.cpu_req)) begin
               state_n = D_OWN;
               gnt_n   = 1'b1;
               halt_n  = 1'b1;
            end else if (bus.cpu_req) begin
               state_n = C_ADDR;
            end
         end
         C_ADDR: begin
            bus.mem_ad = bus.cpu_ad;
            bus.mem_we = bus.cpu_we;
            bus.mem_wd = bus.cpu_wd;
            state_n    = C_DATA;
         end
         C_DATA: begin
            bus.mem_ad = bus.cpu_ad;
            rd_n       = bus.mem_rd;
            ack_n      = 1'b1;
            state_n    = C_ACK;
         end
         C_ACK: begin
            bus.mem_ad = bus.cpu_ad;
            state_n    = IDLE;
         end
         D_OWN: begin
            bus.mem_ad = bus.dbg_ad;
            bus.mem_we = bus.dbg_we;
            bus.mem_wd = bus.dbg_wd;
            if (!bus.dbg_req) begin
               state_n = D_REL;
            end
         end
         D_REL: begin
            gnt_n     = 1'b0;
            halt_n    = 1'b0;
            holdoff_n = HW'(CPU_MIN);
            state_n   = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.cpu_ack  = ack;
   assign bus.cpu_rd   = rd;
   assign bus.cpu_halt = halt;
   assign bus.dbg_gnt  = gnt;
   assign bus.dbg_rd   = bus.mem_rd;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of CPU/debug arbitration, hold-off
// window, async reset and memory mux, against a behavioural byte memory.
module tb_mem_arbiter;
   localparam int AW = 19;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   mem_arbiter #(.AW(AW), .DW(DW), .CPU_MIN(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0] mem [0:(1<<AW)-1];

   always #5 clk = ~clk;

   // synchronous single-port byte memory, read-before-write
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_ad] <= bus.mem_wd;
      bus.mem_rd <= mem[bus.mem_ad];
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // one CPU access; called at a negedge while IDLE, or in C_ACK when
   // chaining, in which case the intervening IDLE cycle is checked too
   task automatic cpu_acc(input logic we, input logic [AW-1:0] ad,
                          input logic [7:0] wd, input logic [7:0] exp,
                          input logic from_ack, input string tag);
      bus.cpu_req = 1'b1;
      bus.cpu_we  = we;
      bus.cpu_ad  = ad;
      bus.cpu_wd  = wd;
      if (from_ack) begin
         @(negedge clk);
         chk({tag, ".idle_ack"}, bus.cpu_ack, 0);
         chk({tag, ".idle_ad"}, bus.mem_ad, 0);
      end
      @(negedge clk);
      chk({tag, ".a_we"}, bus.mem_we, we);
      chk({tag, ".a_ad"}, bus.mem_ad, ad);
      chk({tag, ".a_ack"}, bus.cpu_ack, 0);
      @(negedge clk);
      chk({tag, ".d_we"}, bus.mem_we, 0);
      chk({tag, ".d_ack"}, bus.cpu_ack, 0);
      @(negedge clk);
      chk({tag, ".k_ack"}, bus.cpu_ack, 1);
      chk({tag, ".k_we"}, bus.mem_we, 0);
      if (!we) chk({tag, ".k_rd"}, bus.cpu_rd, exp);
   endtask

   initial begin
      bus.cpu_req = 1'b0;
      bus.cpu_we  = 1'b0;
      bus.cpu_ad  = '0;
      bus.cpu_wd  = '0;
      bus.dbg_req = 1'b0;
      bus.dbg_we  = 1'b0;
      bus.dbg_ad  = '0;
      bus.dbg_wd  = '0;

      // reset state
      @(negedge clk);
      chk("rst_ack", bus.cpu_ack, 0);
      chk("rst_halt", bus.cpu_halt, 0);
      chk("rst_gnt", bus.dbg_gnt, 0);
      chk("rst_rd", bus.cpu_rd, 0);
      chk("rst_we", bus.mem_we, 0);
      chk("rst_ad", bus.mem_ad, 0);
      rst = 1'b0;
      @(negedge clk);

      // 1: CPU write then read of the same byte
      cpu_acc(1'b1, 19'h00010, 8'hA5, 8'h00, 1'b0, "t1w");
      cpu_acc(1'b0, 19'h00010, 8'h00, 8'hA5, 1'b1, "t1r");
      bus.cpu_req = 1'b0;
      @(negedge clk);
      chk("t1_idle_ack", bus.cpu_ack, 0);

      // 2: debug burst of 16 writes, read back, release
      bus.dbg_req = 1'b1;
      @(negedge clk);
      chk("t2_gnt", bus.dbg_gnt, 1);
      chk("t2_halt", bus.cpu_halt, 1);
      for (int i = 0; i < 16; i++) begin
         bus.dbg_we = 1'b1;
         bus.dbg_ad = 19'h00100 + 19'(i);
         bus.dbg_wd = 8'h30 + 8'(i);
         #1;
         chk("t2_mwe", bus.mem_we, 1);
         chk("t2_mad", bus.mem_ad, 32'h100 + i);
         chk("t2_mwd", bus.mem_wd, 32'h30 + i);
         @(negedge clk);
      end
      bus.dbg_we = 1'b0;
      for (int i = 0; i < 16; i++) begin
         bus.dbg_ad = 19'h00100 + 19'(i);
         @(negedge clk);
         chk("t2_drd", bus.dbg_rd, 32'h30 + i);
      end
      bus.dbg_req = 1'b0;
      @(negedge clk);
      chk("t2_rel_gnt", bus.dbg_gnt, 1);
      chk("t2_rel_we", bus.mem_we, 0);
      @(negedge clk);
      chk("t2_off_gnt", bus.dbg_gnt, 0);
      chk("t2_off_halt", bus.cpu_halt, 0);
      repeat (5) @(negedge clk);

      // 3: debug request during CPU read waits for the ack
      bus.cpu_req = 1'b1;
      bus.cpu_we  = 1'b0;
      bus.cpu_ad  = 19'h00105;
      @(negedge clk);
      chk("t3_a_we", bus.mem_we, 0);
      chk("t3_a_ad", bus.mem_ad, 32'h105);
      bus.dbg_req = 1'b1;
      @(negedge clk);
      chk("t3_d_gnt", bus.dbg_gnt, 0);
      chk("t3_d_we", bus.mem_we, 0);
      @(negedge clk);
      chk("t3_k_ack", bus.cpu_ack, 1);
      chk("t3_k_rd", bus.cpu_rd, 8'h35);
      chk("t3_k_gnt", bus.dbg_gnt, 0);
      bus.cpu_req = 1'b0;
      @(negedge clk);
      chk("t3_i_ack", bus.cpu_ack, 0);
      chk("t3_i_gnt", bus.dbg_gnt, 0);
      @(negedge clk);
      chk("t3_o_gnt", bus.dbg_gnt, 1);
      chk("t3_o_halt", bus.cpu_halt, 1);

      // 4: release with CPU pending, debug re-raised: hold-off favours CPU
      bus.dbg_req = 1'b0;
      bus.cpu_req = 1'b1;
      bus.cpu_we  = 1'b0;
      bus.cpu_ad  = 19'h00010;
      @(negedge clk);
      chk("t4_rel_gnt", bus.dbg_gnt, 1);
      chk("t4_rel_ad", bus.mem_ad, 0);
      bus.dbg_req = 1'b1;
      @(negedge clk);
      chk("t4_i_gnt", bus.dbg_gnt, 0);
      chk("t4_i_halt", bus.cpu_halt, 0);
      @(negedge clk);
      chk("t4_a_ad", bus.mem_ad, 32'h10);
      chk("t4_a_gnt", bus.dbg_gnt, 0);
      @(negedge clk);
      chk("t4_d_gnt", bus.dbg_gnt, 0);
      @(negedge clk);
      chk("t4_k_ack", bus.cpu_ack, 1);
      chk("t4_k_rd", bus.cpu_rd, 8'hA5);
      bus.cpu_req = 1'b0;
      @(negedge clk);
      chk("t4_i2_gnt", bus.dbg_gnt, 0);
      chk("t4_i2_ack", bus.cpu_ack, 0);
      @(negedge clk);
      chk("t4_o_gnt", bus.dbg_gnt, 1);
      chk("t4_o_halt", bus.cpu_halt, 1);

      // 5a: async reset in the middle of a debug write
      bus.dbg_we = 1'b1;
      bus.dbg_ad = 19'h00200;
      bus.dbg_wd = 8'h77;
      #1;
      chk("t5_pre_we", bus.mem_we, 1);
      rst = 1'b1;
      #1;
      chk("t5_d_we", bus.mem_we, 0);
      chk("t5_d_gnt", bus.dbg_gnt, 0);
      chk("t5_d_halt", bus.cpu_halt, 0);
      chk("t5_d_ad", bus.mem_ad, 0);
      chk("t5_d_rd", bus.cpu_rd, 0);
      @(negedge clk);
      bus.dbg_req = 1'b0;
      bus.dbg_we  = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("t5_post_gnt", bus.dbg_gnt, 0);
      chk("t5_post_we", bus.mem_we, 0);

      // 5b: async reset in the C_ADDR cycle of a CPU write
      bus.cpu_req = 1'b1;
      bus.cpu_we  = 1'b1;
      bus.cpu_ad  = 19'h00020;
      bus.cpu_wd  = 8'h5A;
      @(negedge clk);
      chk("t5_a_we", bus.mem_we, 1);
      rst = 1'b1;
      #1;
      chk("t5_r_we", bus.mem_we, 0);
      chk("t5_r_ad", bus.mem_ad, 0);
      chk("t5_r_wd", bus.mem_wd, 0);
      chk("t5_r_ack", bus.cpu_ack, 0);
      @(negedge clk);
      bus.cpu_req = 1'b0;
      bus.cpu_we  = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("t5_i_ack", bus.cpu_ack, 0);
      chk("t5_i_ad", bus.mem_ad, 0);
      repeat (3) @(negedge clk);
      chk("t5_no_ack", bus.cpu_ack, 0);

      // 6: address extremes, back-to-back CPU accesses
      cpu_acc(1'b1, 19'h7FFFF, 8'hC3, 8'h00, 1'b0, "t6w0");
      cpu_acc(1'b1, 19'h00000, 8'h3C, 8'h00, 1'b1, "t6w1");
      cpu_acc(1'b0, 19'h7FFFF, 8'h00, 8'hC3, 1'b1, "t6r0");
      cpu_acc(1'b0, 19'h00000, 8'h00, 8'h3C, 1'b1, "t6r1");
      bus.cpu_req = 1'b0;
      @(negedge clk);
      chk("t6_i_ack", bus.cpu_ack, 0);
      chk("t6_i_we", bus.mem_we, 0);
      @(negedge clk);
      chk("t6_i2_ack", bus.cpu_ack, 0);
      chk("t6_i2_ad", bus.mem_ad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
